// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared types and constants for the frog-race match referee.
//  Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

    localparam int SCORE_W           = 4;
    localparam int DEFAULT_WIN_SCORE = 3;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        OVERTIME = 2'd1,
        P1_WIN   = 2'd2,
        P2_WIN   = 2'd3
    } referee_state_t;

endpackage : frogger_pkg
`default_nettype wire

// File: rtl/goal_counter.sv
`default_nettype none
// ============================================================================
//  Module      : goal_counter
//  Description : Per-player score counter that saturates at max; the next
//                count is exported so the referee can decide on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module goal_counter
    import frogger_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    input  logic [SCORE_W-1:0] max,
    output logic [SCORE_W-1:0] count,
    output logic [SCORE_W-1:0] count_next
);

    localparam logic [SCORE_W-1:0] c_one = {{(SCORE_W-1){1'b0}}, 1'b1};

    logic [SCORE_W-1:0] r_count;
    logic [SCORE_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (inc && (r_count < max)) begin
            w_count_next = r_count + c_one;
        end
    end

    always_ff @(posedge clk) begin
        r_count <= w_count_next;
    end

    assign count      = r_count;
    assign count_next = w_count_next;

endmodule : goal_counter
`default_nettype wire

// File: rtl/match_referee.sv
`default_nettype none
// ============================================================================
//  Module      : match_referee
//  Description : Scores a two-frog race and declares a winner or overtime.
//                Optional match timeout enabled by macro MATCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_referee
    import frogger_pkg::*;
#(
    parameter int WIN_SCORE     = DEFAULT_WIN_SCORE,
    parameter int TIMEOUT_TICKS = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_goal,
    input  logic               p2_goal,
    input  logic               tick,
    output logic               f1,
    output logic               f2,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               overtime
);

    localparam logic [SCORE_W-1:0] c_win = SCORE_W'(WIN_SCORE);

    referee_state_t     r_state;
    referee_state_t     w_state_next;
    logic               r_f1;
    logic               r_f2;
    logic               r_overtime;
    logic               w_play;
    logic [SCORE_W-1:0] w_p1_next;
    logic [SCORE_W-1:0] w_p2_next;
    logic               w_p1_reach;
    logic               w_p2_reach;
    logic               w_timeout;

    assign w_play = (r_state == PLAY);

    // Scores only move during regular play; reset doubles as the counter clear.
    goal_counter u_p1_counter (
        .clk        (clk),
        .clear      (reset),
        .inc        (p1_goal & w_play),
        .max        (c_win),
        .count      (p1_score),
        .count_next (w_p1_next)
    );

    goal_counter u_p2_counter (
        .clk        (clk),
        .clear      (reset),
        .inc        (p2_goal & w_play),
        .max        (c_win),
        .count      (p2_score),
        .count_next (w_p2_next)
    );

    assign w_p1_reach = p1_goal && (w_p1_next == c_win);
    assign w_p2_reach = p2_goal && (w_p2_next == c_win);

`ifdef MATCH_TIMEOUT_EN
    localparam logic [7:0] c_timeout = 8'(TIMEOUT_TICKS);

    logic [7:0] r_tick_count;
    logic       w_tick_play;

    assign w_tick_play = tick && w_play;
    assign w_timeout   = w_tick_play && ((r_tick_count + 8'd1) == c_timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_count <= 8'd0;
        end else if (w_tick_play) begin
            r_tick_count <= r_tick_count + 8'd1;
        end
    end
`else
    logic w_unused_tick;

    assign w_unused_tick = tick;
    assign w_timeout     = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PLAY: begin
                // A goal that ends the match outranks a coincident timeout.
                if (w_p1_reach && w_p2_reach) begin
                    w_state_next = OVERTIME;
                end else if (w_p1_reach) begin
                    w_state_next = P1_WIN;
                end else if (w_p2_reach) begin
                    w_state_next = P2_WIN;
                end else if (w_timeout) begin
                    if (w_p1_next > w_p2_next) begin
                        w_state_next = P1_WIN;
                    end else if (w_p2_next > w_p1_next) begin
                        w_state_next = P2_WIN;
                    end else begin
                        w_state_next = OVERTIME;
                    end
                end
            end
            OVERTIME: begin
                if (p1_goal && !p2_goal) begin
                    w_state_next = P1_WIN;
                end else if (p2_goal && !p1_goal) begin
                    w_state_next = P2_WIN;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PLAY;
            r_f1       <= 1'b0;
            r_f2       <= 1'b0;
            r_overtime <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_f1       <= (w_state_next == P1_WIN);
            r_f2       <= (w_state_next == P2_WIN);
            r_overtime <= (w_state_next == OVERTIME);
        end
    end

    assign f1       = r_f1;
    assign f2       = r_f2;
    assign overtime = r_overtime;

endmodule : match_referee
`default_nettype wire

// File: tb/tb_match_referee.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_referee
//  Description : Self-checking bench for match_referee (scoreboard queue of
//                expected scores/flags, one entry per clocked stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_match_referee;
    import frogger_pkg::*;

    typedef struct packed {
        logic [3:0] p1;
        logic [3:0] p2;
        logic       f1;
        logic       f2;
        logic       ot;
    } exp_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       p1_goal  = 1'b0;
    logic       p2_goal  = 1'b0;
    logic       tick     = 1'b0;
    logic       f1;
    logic       f2;
    logic       overtime;
    logic [3:0] p1_score;
    logic [3:0] p2_score;

    exp_t sb_q[$];
    exp_t e;
    exp_t o;
    int   n_checks = 0;
    int   n_fail   = 0;

    match_referee #(
        .WIN_SCORE     (3),
        .TIMEOUT_TICKS (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p1_goal  (p1_goal),
        .p2_goal  (p2_goal),
        .tick     (tick),
        .f1       (f1),
        .f2       (f2),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .overtime (overtime)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return {p1_score, p2_score, f1, f2, overtime};
    endfunction

    // Drive one cycle of inputs, sample 1 ns after the rising edge.
    task automatic cyc(input logic a, input logic b, input logic t, input logic r);
        @(negedge clk);
        p1_goal = a; p2_goal = b; tick = t; reset = r;
        @(posedge clk);
        #1;
        p1_goal = 1'b0; p2_goal = 1'b0; tick = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back({4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
            cyc(i[0], i[0], i[0], 1'b1);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask

    task automatic test_p1_win();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                sb_q.push_back({4'(k), 4'd0, (k == 3), 1'b0, 1'b0});
                cyc(i == 0, 1'b0, 1'b0, 1'b0);
                e = sb_q.pop_front(); o = observed(); n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL p1_win_k%0d_c%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                             k, i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
                end
            end
        end
    endtask

    task automatic test_ignore_after_win();
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back({4'd3, 4'd0, 1'b1, 1'b0, 1'b0});
            cyc(1'b0, i[0] == 1'b0, i[1], 1'b0);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold_p1_win_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask

    task automatic test_overtime();
        logic [1:0] stim [8];
        exp_t       ex   [8];
        stim = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01};
        ex   = '{{4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd1, 4'd1, 3'b000},
                 {4'd2, 4'd1, 3'b000}, {4'd2, 4'd2, 3'b000}, {4'd3, 4'd3, 3'b001},
                 {4'd3, 4'd3, 3'b001}, {4'd3, 4'd3, 3'b010}};
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(ex[i]);
            cyc(stim[i][1], stim[i][0], 1'b0, i == 0);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL overtime_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [2:0] stim [6];
        exp_t       ex   [6];
        // stim bits: {reset, p1_goal, p2_goal}
        stim = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b110, 3'b001};
        ex   = '{{4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd2, 4'd0, 3'b000},
                 {4'd2, 4'd1, 3'b000}, {4'd0, 4'd0, 3'b000}, {4'd0, 4'd1, 3'b000}};
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(ex[i]);
            cyc(stim[i][1], stim[i][0], 1'b0, stim[i][2]);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_prio_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask

    task automatic test_p2_win();
        logic [2:0] stim [6];
        exp_t       ex   [6];
        // stim bits: {reset, p1_goal, p2_goal}
        stim = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
        ex   = '{{4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd1, 4'd1, 3'b000},
                 {4'd1, 4'd2, 3'b000}, {4'd1, 4'd3, 3'b010}, {4'd1, 4'd3, 3'b010}};
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(ex[i]);
            cyc(stim[i][1], stim[i][0], 1'b0, stim[i][2]);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL p2_win_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask

`ifdef MATCH_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] stim [23];
        exp_t       ex   [23];
        // stim bits: {reset, p1_goal, p2_goal, tick}
        stim = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0101};
        ex   = '{{4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd1, 4'd1, 3'b000},
                 {4'd1, 4'd2, 3'b000}, {4'd1, 4'd2, 3'b000}, {4'd1, 4'd2, 3'b000},
                 {4'd1, 4'd2, 3'b000}, {4'd1, 4'd2, 3'b010},
                 {4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd1, 4'd1, 3'b000},
                 {4'd1, 4'd1, 3'b000}, {4'd1, 4'd1, 3'b000}, {4'd1, 4'd1, 3'b000},
                 {4'd1, 4'd1, 3'b001},
                 {4'd0, 4'd0, 3'b000}, {4'd1, 4'd0, 3'b000}, {4'd2, 4'd0, 3'b000},
                 {4'd2, 4'd1, 3'b000}, {4'd2, 4'd2, 3'b000}, {4'd2, 4'd2, 3'b000},
                 {4'd2, 4'd2, 3'b000}, {4'd3, 4'd2, 3'b100}};
        for (int i = 0; i < 23; i++) begin
            sb_q.push_back(ex[i]);
            cyc(stim[i][2], stim[i][1], stim[i][0], stim[i][3]);
            e = sb_q.pop_front(); o = observed(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                         i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
            end
        end
    endtask
`else
    task automatic test_tick_ignored();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            if ((i % 50) == 0) sb_q.push_back({4'd0, 4'd0, 3'b000});
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if ((i % 50) == 0) begin
                e = sb_q.pop_front(); o = observed(); n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL tick_ignored_%0d: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                             i, o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
                end
            end
        end
        sb_q.push_back({4'd1, 4'd0, 3'b000});
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        e = sb_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL tick_then_goal: got %0d-%0d f1f2ot=%b%b%b, want %0d-%0d f1f2ot=%b%b%b",
                     o.p1, o.p2, o.f1, o.f2, o.ot, e.p1, e.p2, e.f1, e.f2, e.ot);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_p1_win();
        test_ignore_after_win();
        test_reset();
        test_overtime();
        test_reset_priority();
        test_p2_win();
`ifdef MATCH_TIMEOUT_EN
        test_timeout();
`else
        test_tick_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_match_referee
`default_nettype wire
